// File: rtl/parking_slot_allocator_if.sv
// rtl/parking_slot_allocator_if.sv - entry/exit handshake and occupancy status bundle
interface parking_slot_allocator_if;
    logic       entry_req;
    logic       car_passed;
    logic       exit_valid;
    logic [7:0] exit_location;
    logic [7:0] park_location;
    logic       slot_valid;
    logic       entry_ack;
    logic       entry_reject;
    logic       entry_timeout;
    logic       exit_error;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       full;
    logic       empty;

    modport master (
        output entry_req, car_passed, exit_valid, exit_location,
        input  park_location, slot_valid, entry_ack, entry_reject, entry_timeout,
        input  exit_error, parking_capacity, free_count, full, empty
    );

    modport slave (
        input  entry_req, car_passed, exit_valid, exit_location,
        output park_location, slot_valid, entry_ack, entry_reject, entry_timeout,
        output exit_error, parking_capacity, free_count, full, empty
    );
endinterface

// File: rtl/parking_slot_allocator.sv
// rtl/parking_slot_allocator.sv - 8-slot entry/exit controller owning the occupancy bitmap
module parking_slot_allocator #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input logic                     clk,
    input logic                     rst,
    parking_slot_allocator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, REJECT, DONE} state_e;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    park_q;
    logic [7:0]    cap_q;
    logic          sv_q, ack_q, rej_q, to_q, err_q;
    logic [3:0]    free_q;
    logic          full_q, empty_q;

    logic [7:0]    pick;
    logic          exit_legal;
    logic          commit;
    logic [7:0]    cap_d;
    logic [3:0]    free_d;

    always_comb begin
        // Lot priority: bits 4..7 ascending, then 3..0 descending
        pick = 8'h00;
        for (int i = 4; i < 8; i++) begin
            if (pick == 8'h00 && !cap_q[i]) pick[i] = 1'b1;
        end
        for (int i = 3; i >= 0; i--) begin
            if (pick == 8'h00 && !cap_q[i]) pick[i] = 1'b1;
        end

        exit_legal = bus.exit_valid && $onehot(bus.exit_location)
                     && ((bus.exit_location & cap_q) != 8'h00);
        commit     = (state_q == GRANT) && bus.car_passed;
        cap_d      = (cap_q | (commit ? park_q : 8'h00))
                     & ~(exit_legal ? bus.exit_location : 8'h00);

        free_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            free_d = free_d + {3'b000, ~cap_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            park_q  <= 8'h00;
            cap_q   <= 8'h00;
            sv_q    <= 1'b0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
            free_q  <= 4'd8;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cap_q   <= cap_d;
            free_q  <= free_d;
            full_q  <= (cap_d == 8'hFF);
            empty_q <= (cap_d == 8'h00);
            err_q   <= bus.exit_valid && !exit_legal;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.entry_req) begin
                        if (cap_q != 8'hFF) begin
                            park_q  <= pick;
                            sv_q    <= 1'b1;
                            timer_q <= '0;
                            state_q <= GRANT;
                        end else begin
                            rej_q   <= 1'b1;
                            state_q <= REJECT;
                        end
                    end
                end
                GRANT: begin
                    // A car_passed on the final timeout cycle still commits
                    if (bus.car_passed) begin
                        ack_q   <= 1'b1;
                        park_q  <= 8'h00;
                        sv_q    <= 1'b0;
                        state_q <= DONE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        to_q    <= 1'b1;
                        park_q  <= 8'h00;
                        sv_q    <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REJECT, DONE: begin
                    if (!bus.entry_req) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.park_location    = park_q;
    assign bus.slot_valid       = sv_q;
    assign bus.entry_ack        = ack_q;
    assign bus.entry_reject     = rej_q;
    assign bus.entry_timeout    = to_q;
    assign bus.exit_error       = err_q;
    assign bus.parking_capacity = cap_q;
    assign bus.free_count       = free_q;
    assign bus.full             = full_q;
    assign bus.empty            = empty_q;
endmodule

// File: doc/parking_slot_allocator.md
Name: parking_slot_allocator

Overview:
- Sequential entry/exit controller for the 8-slot lot.
- Sits directly upstream of the capacity-update logic and owns the registered occupancy bitmap.
- On a car-entry request it picks a free slot in the fixed lot priority order and presents it as a one-hot park_location.
- It holds the reservation until the gate confirms the car has passed or a timeout expires. It also releases slots on exit events.

Parameters:
- TIMEOUT, 16, max cycles in GRANT without car_passed before the reservation is aborted (must be ≥2).
- TW, 5, timer width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- entry_req  in  1  car waiting at entry gate; level, held until ack/reject/timeout is seen.
- car_passed  in  1  gate sensor pulse: car has entered the granted slot.
- exit_valid  in  1  one-cycle exit event.
- exit_location  in  8  one-hot slot being vacated; qualified by exit_valid.
- park_location  out  8  one-hot granted slot; 0x00 outside GRANT.
- slot_valid  out  1  high while in GRANT.
- entry_ack  out  1  one-cycle pulse: reservation committed.
- entry_reject  out  1  one-cycle pulse: lot full at request.
- entry_timeout  out  1  one-cycle pulse: reservation aborted.
- exit_error  out  1  one-cycle pulse: illegal exit.
- parking_capacity  out  8  occupancy bitmap; 1 = occupied.
- free_count  out  4  number of zero bits in parking_capacity, 0..8.
- full  out  1  parking_capacity == 0xFF.
- empty  out  1  parking_capacity == 0x00.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs registered. On rst:
  - state = IDLE
  - parking_capacity = 0x00, park_location = 0x00
  - all pulses = 0, slot_valid = 0
  - free_count = 8, full = 0, empty = 1
  - timer = 0
- rst has priority over every other input, including mid-GRANT; any pending reservation is dropped.
- Slot priority, highest first: bit4, bit5, bit6, bit7, bit3, bit2, bit1, bit0. The grant is the first zero bit of parking_capacity in that order.
- FSM states: IDLE, GRANT, REJECT, DONE.
- IDLE:
  - If entry_req=1 and free_count>0: register the chosen one-hot slot into park_location, clear timer, go to GRANT. slot_valid is high the cycle after the request is sampled (1-cycle latency).
  - If entry_req=1 and full: pulse entry_reject, go to REJECT.
- GRANT:
  - timer increments each cycle.
  - car_passed=1: parking_capacity |= park_location; entry_ack pulses; park_location clears to 0x00; go to DONE. All of these take effect on the same edge.
  - Otherwise, when timer reaches TIMEOUT-1: entry_timeout pulses, park_location clears to 0x00, go to DONE. The capacity is unchanged.
  - car_passed on the timeout cycle wins: commit, no timeout pulse.
- REJECT and DONE: wait for entry_req=0, then go to IDLE. No further pulses are issued while the request is held.
- car_passed outside GRANT is ignored.
- Exit handling runs in every state. The exit is legal only if exit_location is exactly one-hot and its bit is set in parking_capacity.
  - Legal exit: clear that bit next edge.
  - Illegal exit (zero, multi-hot, or a free slot): pulse exit_error; capacity unchanged.
- A granted-but-uncommitted slot is not occupied, so an exit on it is an error.
- Simultaneous commit and legal exit on the same edge: both apply, i.e. next = (cap | park_location) & ~exit_location.
- The grant choice is fixed when GRANT is entered. Exits during GRANT do not change park_location.
- free_count, full and empty are computed from the next-state bitmap, so they are coherent with parking_capacity in every cycle.

Test Plan:
- Reset, then 8 back-to-back entries (car_passed 2 cycles after slot_valid, entry_req dropped after ack) → park_location sequence 0x10, 0x20, 0x40, 0x80, 0x08, 0x04, 0x02, 0x01. Final state: capacity 0xFF, free_count 0, full 1; one entry_ack per entry.
- Lot at 0xFF, entry_req held 10 cycles → exactly one entry_reject pulse, slot_valid never 1, capacity stays 0xFF.
- Lot at 0xFF, exit_valid with 0x20 → capacity 0xDF, free_count 1, full 0. Next entry is granted 0x20 and commit restores 0xFF.
- Empty lot, entry granted 0x10, no car_passed → entry_timeout on GRANT cycle 16, park_location 0x00, capacity 0x00. car_passed arriving later is ignored.
- Capacity 0x80, exit_location 0x03 then 0x01 → exit_error pulses twice, capacity stays 0x80. A simultaneous commit of 0x10 plus exit 0x80 → capacity 0x10.
- rst asserted during GRANT (granted 0x10, capacity 0x0F) → next cycle: IDLE, capacity 0x00, park_location 0x00, free_count 8, empty 1, no pulses.
